i2s_sample_tx: RTL and testbench

//  Consumes the 24-bit mixed sample produced by the mixer and serializes it to the audio DAC/codec as I2S.

---
 rtl/i2s_sample_tx.sv | 142 ++++++++++++++
 tb/tb_i2s_sample_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
// ---------------------------------------------------------------------------
// i2s_sample_tx
//
// Purpose:
//   Serializes the 24-bit mixed mono sample to the DAC/codec as I2S. The same
//   sample goes out in both the left and the right slot of each frame.
//   SCLK, LRCLK and SDATA are all generated from clk. Once per frame a
//   one-clk request pulse asks upstream for the next sample. That pulse is
//   the mixer/voice sample clock.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous, active-low reset
//   sample_in     in   mixed sample, two's complement, SAMPLE_W bits
//   sample_valid  in   1-clk strobe; loads sample_in into the hold register
//   sample_req    out  1-clk pulse at frame start (next sample wanted)
//   underrun      out  1-clk pulse: frame started with no new sample held
//   overrun       out  1-clk pulse: sample_valid while hold was already full
//   sclk          out  I2S bit clock, clk/(2*CLK_DIV)
//   lrclk         out  I2S word select, 0 = left, 1 = right
//   sdata         out  I2S serial data, MSB first, changes on SCLK fall
// ---------------------------------------------------------------------------
module i2s_sample_tx #(
    parameter int CLK_DIV  = 8,
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       sample_req,
    output logic                       underrun,
    output logic                       overrun,
    output logic                       sclk,
    output logic                       lrclk,
    output logic                       sdata
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    logic [DIV_W-1:0]           div_cnt;
    logic [BIT_W-1:0]           bit_cnt;
    logic signed [SAMPLE_W-1:0] hold;
    logic                       hold_full;
    logic signed [SAMPLE_W-1:0] frame_data;

    logic                       div_tc;
    logic                       fall_evt;
    logic                       frame_start;
    logic [BIT_W-1:0]           bit_nxt;
    logic signed [SAMPLE_W-1:0] frame_nxt;

    // Word select for bit position p: high over the right slot, advanced by
    // one bit so that it leads the MSB as I2S requires.
    function automatic logic lr_bit(input logic [BIT_W-1:0] p);
        int unsigned pi;
        pi = {{(32-BIT_W){1'b0}}, p};
        return (pi >= SLOT_W - 1) && (pi <= FRAME_W - 2);
    endfunction

    // Serial data bit for bit position p. The sample goes MSB first at the
    // head of each slot. The remaining slot bits are zero padding.
    function automatic logic slot_bit(input logic [BIT_W-1:0]           p,
                                      input logic signed [SAMPLE_W-1:0] d);
        int unsigned             pi;
        int unsigned             off;
        logic [SAMPLE_W-1:0]     sh;
        pi = {{(32-BIT_W){1'b0}}, p};
        if (pi < SAMPLE_W) begin
            off = pi;
        end else if ((pi >= SLOT_W) && (pi < SLOT_W + SAMPLE_W)) begin
            off = pi - SLOT_W;
        end else begin
            return 1'b0;
        end
        sh = d << off;
        return sh[SAMPLE_W-1];
    endfunction

    assign div_tc      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_evt    = div_tc && sclk;
    assign frame_start = fall_evt && (bit_cnt == BIT_W'(FRAME_W - 1));
    assign bit_nxt     = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0
                                                          : bit_cnt + BIT_W'(1);
    // With no fresh sample, the previous frame repeats.
    assign frame_nxt   = (frame_start && hold_full) ? hold : frame_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt    <= '0;
            bit_cnt    <= BIT_W'(FRAME_W - 1);
            hold       <= '0;
            hold_full  <= 1'b0;
            frame_data <= '0;
            sclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;

            // Bit clock divider
            if (div_tc) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // Bit position and serial outputs advance on SCLK fall. The DAC
            // samples them on the following rise.
            if (fall_evt) begin
                bit_cnt    <= bit_nxt;
                lrclk      <= lr_bit(bit_nxt);
                sdata      <= slot_bit(bit_nxt, frame_nxt);
                frame_data <= frame_nxt;
            end

            if (frame_start) begin
                sample_req <= 1'b1;
                underrun   <= ~hold_full;
                hold_full  <= 1'b0;
            end

            // A capture in the frame-start clk refills hold after the old
            // value has moved to frame_data, so it is not an overrun.
            if (sample_valid) begin
                hold      <= sample_in;
                hold_full <= 1'b1;
                overrun   <= hold_full && !frame_start;
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_tx.sv
module tb_i2s_sample_tx;

    localparam int CLK_DIV    = 8;
    localparam int SAMPLE_W   = 24;
    localparam int SLOT_W     = 32;
    localparam int BIT_CLKS   = 2 * CLK_DIV;
    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;
    localparam int NFR        = 16;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       sample_req;
    logic                       underrun;
    logic                       overrun;
    logic                       sclk;
    logic                       lrclk;
    logic                       sdata;

    int checks = 0;
    int errors = 0;
    int cyc;

    // Frame-level model: which frames receive a fresh sample, and the value.
    bit                has [NFR];
    logic [SAMPLE_W-1:0] smp [NFR];
    bit                ovr_at [int];

    i2s_sample_tx #(
        .CLK_DIV (CLK_DIV),
        .SAMPLE_W(SAMPLE_W),
        .SLOT_W  (SLOT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_req  (sample_req),
        .underrun    (underrun),
        .overrun     (overrun),
        .sclk        (sclk),
        .lrclk       (lrclk),
        .sdata       (sdata)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check_bit(input string nm, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0b expected %0b", nm, cyc, act, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NFR; i++) begin
            has[i] = 1'b0;
            smp[i] = '0;
        end
        ovr_at.delete();
    endtask

    // A sample captured at edge c is sent in the frame after the one running
    // at c. Frame f starts at edge BIT_CLKS + f*FRAME_CLKS.
    task automatic model_capture(input int c, input logic [SAMPLE_W-1:0] v);
        int tf;
        tf = (c < BIT_CLKS) ? 0 : (c - BIT_CLKS) / FRAME_CLKS + 1;
        if (has[tf]) ovr_at[c] = 1'b1;
        has[tf] = 1'b1;
        smp[tf] = v;
    endtask

    function automatic logic [SAMPLE_W-1:0] frame_value(input int f);
        logic [SAMPLE_W-1:0] v;
        v = '0;
        for (int i = 0; i <= f && i < NFR; i++)
            if (has[i]) v = smp[i];
        return v;
    endfunction

    always @(negedge clk) begin : cmp
        int n, k, p, f;
        logic [SAMPLE_W-1:0] v, t;
        logic es, el, ed, er, eu, eo;
        if (reset_n) begin
            n  = cyc;
            es = ((n / CLK_DIV) % 2) == 1;
            el = 1'b0; ed = 1'b0; er = 1'b0; eu = 1'b0;
            eo = ovr_at.exists(n);
            if (n >= BIT_CLKS) begin
                k  = n / BIT_CLKS;
                p  = (k - 1) % FRAME_BITS;
                f  = (k - 1) / FRAME_BITS;
                v  = frame_value(f);
                el = (p >= SLOT_W - 1) && (p <= FRAME_BITS - 2);
                if (p < SAMPLE_W) begin
                    t = v << p;
                    ed = t[SAMPLE_W-1];
                end else if (p >= SLOT_W && p < SLOT_W + SAMPLE_W) begin
                    t = v << (p - SLOT_W);
                    ed = t[SAMPLE_W-1];
                end
                er = ((n - BIT_CLKS) % FRAME_CLKS) == 0;
                eu = er && !has[f];
            end
            check_bit("model_sclk",       sclk,       es);
            check_bit("model_lrclk",      lrclk,      el);
            check_bit("model_sdata",      sdata,      ed);
            check_bit("model_sample_req", sample_req, er);
            check_bit("model_underrun",   underrun,   eu);
            check_bit("model_overrun",    overrun,    eo);
        end
    end

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc != c) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                $display("FAIL wait_cyc timeout waiting for cyc %0d", c);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic send(input int c, input logic [SAMPLE_W-1:0] v);
        wait_cyc(c - 1);
        sample_in    = v;
        sample_valid = 1'b1;
        model_capture(c, v);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_sclk"},       sclk,       1'b0);
        check_bit({tag, "_lrclk"},      lrclk,      1'b0);
        check_bit({tag, "_sdata"},      sdata,      1'b0);
        check_bit({tag, "_sample_req"}, sample_req, 1'b0);
        check_bit({tag, "_underrun"},   underrun,   1'b0);
        check_bit({tag, "_overrun"},    overrun,    1'b0);
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        // Idle timing: first rise at 8, first req/underrun at 16
        wait_cyc(7);  check_bit("sclk_low_7", sclk, 1'b0);
        wait_cyc(8);  check_bit("sclk_rise_8", sclk, 1'b1);
        wait_cyc(16);
        check_bit("first_req", sample_req, 1'b1);
        check_bit("first_underrun", underrun, 1'b1);
        check_bit("sclk_fall_16", sclk, 1'b0);

        // 0xA5C3F0 goes out in frame 1
        send(100, 24'hA5C3F0);
        wait_cyc(1048); check_bit("a5_p0", sdata, 1'b1);
        wait_cyc(1064); check_bit("a5_p1", sdata, 1'b0);
        wait_cyc(1080); check_bit("a5_p2", sdata, 1'b1);
        wait_cyc(1096); check_bit("a5_p3", sdata, 1'b0);
        wait_cyc(1432); check_bit("a5_pad_p24", sdata, 1'b0);
        wait_cyc(1528); check_bit("lr_p30", lrclk, 1'b0);
        wait_cyc(1544); check_bit("lr_p31", lrclk, 1'b1);
        wait_cyc(1560); check_bit("a5_right_p32", sdata, 1'b1);

        // Frame 2 has no new sample: underrun and repeat
        wait_cyc(2064); check_bit("repeat_underrun", underrun, 1'b1);
        wait_cyc(2072); check_bit("repeat_p0", sdata, 1'b1);

        // Negative full-scale-ish 0x800001 in frame 3, two strobes for frame 4
        send(2200, 24'h800001);
        wait_cyc(3096); check_bit("neg_p0", sdata, 1'b1);
        wait_cyc(3112); check_bit("neg_p1", sdata, 1'b0);
        send(3200, 24'h111111);
        wait_cyc(3448); check_bit("neg_p22", sdata, 1'b0);
        wait_cyc(3464); check_bit("neg_p23", sdata, 1'b1);
        wait_cyc(3480); check_bit("neg_pad_p24", sdata, 1'b0);
        send(3500, 24'h222222);
        check_bit("overrun_pulse", overrun, 1'b1);
        wait_cyc(3608); check_bit("neg_right_p32", sdata, 1'b1);
        wait_cyc(3976); check_bit("neg_right_p55", sdata, 1'b1);
        wait_cyc(4152); check_bit("second_wins_p2", sdata, 1'b1);

        // Strobe coincident with frame start of frame 5
        send(4200, 24'h333333);
        send(5136, 24'h444444);
        check_bit("coinc_req", sample_req, 1'b1);
        check_bit("coinc_no_underrun", underrun, 1'b0);
        check_bit("coinc_no_overrun", overrun, 1'b0);
        wait_cyc(5160); check_bit("old_hold_p1", sdata, 1'b0);
        wait_cyc(5176); check_bit("old_hold_p2", sdata, 1'b1);
        wait_cyc(6160); check_bit("next_no_underrun", underrun, 1'b0);
        wait_cyc(6184); check_bit("new_hold_p1", sdata, 1'b1);

        // Reset asserted mid-frame at p=40
        wait_cyc(7828); check_bit("pre_reset_lrclk", lrclk, 1'b1);
        #3 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cyc(8);  check_bit("rst2_sclk_rise", sclk, 1'b1);
        wait_cyc(16);
        check_bit("rst2_first_req", sample_req, 1'b1);
        check_bit("rst2_first_underrun", underrun, 1'b1);
        wait_cyc(BIT_CLKS + FRAME_CLKS + 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
